// File: rtl/ysyx_24090003_mem_slave.sv
// Word-addressed memory responder with a single outstanding request and a programmable response delay.
// Optional YSYX_24090003_MEM_RAND_DELAY_EN adds 0..3 LFSR-driven extra wait cycles per transaction.
module ysyx_24090003_mem_slave #(
    parameter logic [31:0] BASE       = 32'h8000_0000,
    parameter int          DEPTH_LOG2 = 12,
    parameter int          LATENCY    = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [31:0] i_req_addr,
    input  logic        i_req_wen,
    input  logic [31:0] i_req_wdata,
    input  logic [3:0]  i_req_wmask,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err
);
    // state | meaning
    // IDLE  | ready for a request
    // WAIT  | request latched, counting down the delay
    // RESP  | response presented, waiting for i_rsp_ready
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    localparam int          WORDS = 1 << DEPTH_LOG2;
    localparam logic [32:0] SPAN  = 33'(WORDS) << 2;

    state_t      state, state_nxt;
    logic [4:0]  cnt, cnt_load;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  wmask_q;
    logic        wen_q;
    logic        accept, access;
    logic [31:0] off;
    logic        in_range;
    logic [DEPTH_LOG2-1:0] idx;

    logic [31:0] mem [WORDS];

    assign off      = addr_q - BASE;
    assign in_range = (addr_q >= BASE) && ({1'b0, off} < SPAN);
    assign idx      = off[DEPTH_LOG2+1:2];

`ifdef YSYX_24090003_MEM_RAND_DELAY_EN
    logic [7:0] lfsr;

    always_ff @(posedge i_clk) begin
        if (i_rst)
            lfsr <= 8'hA5;
        else
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    assign cnt_load = 5'(LATENCY) + {3'b000, lfsr[1:0]};
`else
    assign cnt_load = 5'(LATENCY);
`endif

    // Every request passes through WAIT for at least one cycle, so the response
    // appears LATENCY+1 edges after accept, including when the delay is zero.
    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        access      = 1'b0;
        o_req_ready = 1'b0;
        o_rsp_valid = 1'b0;
        case (state)
            S_IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) begin
                    accept    = 1'b1;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt == 5'd0) begin
                    access    = 1'b1;
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                o_rsp_valid = 1'b1;
                if (i_rsp_ready)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= S_IDLE;
            cnt         <= 5'd0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            wen_q       <= 1'b0;
            o_rsp_rdata <= '0;
            o_rsp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                addr_q  <= i_req_addr;
                wdata_q <= i_req_wdata;
                wmask_q <= i_req_wmask;
                wen_q   <= i_req_wen;
                cnt     <= cnt_load;
            end else if (state == S_WAIT && cnt != 5'd0) begin
                cnt <= cnt - 5'd1;
            end
            if (access) begin
                o_rsp_rdata <= (in_range && !wen_q) ? mem[idx] : 32'h0;
                o_rsp_err   <= !in_range;
            end else if (state == S_RESP && i_rsp_ready) begin
                o_rsp_rdata <= '0;
                o_rsp_err   <= 1'b0;
            end
        end
    end

    // Storage has no reset; a reset on the access edge must still cancel the write.
    always_ff @(posedge i_clk) begin
        if (!i_rst && access && wen_q && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask_q[b])
                    mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_ysyx_24090003_mem_slave.sv
// Directed self-checking bench for ysyx_24090003_mem_slave.
module tb_ysyx_24090003_mem_slave;
`ifdef YSYX_24090003_MEM_RAND_DELAY_EN
    localparam int LAT     = 0;
    localparam int LAT_MIN = LAT + 1;
    localparam int LAT_MAX = LAT + 4;
`else
    localparam int LAT     = 2;
    localparam int LAT_MIN = LAT + 1;
    localparam int LAT_MAX = LAT + 1;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic [31:0] i_req_addr = '0;
    logic        i_req_wen = 1'b0;
    logic [31:0] i_req_wdata = '0;
    logic [3:0]  i_req_wmask = '0;
    logic        o_rsp_valid;
    logic        i_rsp_ready = 1'b1;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_err;

    int checks = 0;
    int errors = 0;

    ysyx_24090003_mem_slave #(
        .BASE(32'h8000_0000), .DEPTH_LOG2(12), .LATENCY(LAT)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_addr(i_req_addr), .i_req_wen(i_req_wen),
        .i_req_wdata(i_req_wdata), .i_req_wmask(i_req_wmask),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err)
    );

    always #5 i_clk = ~i_clk;

    // Issues one request from IDLE, returns the edge count from accept to valid;
    // completes the handshake when i_rsp_ready is high.
    task automatic do_txn(input logic [31:0] a, input logic w, input logic [31:0] d,
                          input logic [3:0] m, output logic [31:0] rd, output logic e,
                          output int lat);
        lat = 0;
        rd  = '0;
        e   = 1'b0;
        i_req_valid = 1'b1; i_req_addr = a; i_req_wen = w; i_req_wdata = d; i_req_wmask = m;
        @(posedge i_clk); #1;
        i_req_valid = 1'b0;
        do begin
            @(posedge i_clk); #1;
            lat++;
        end while (o_rsp_valid !== 1'b1 && lat < 40);
        if (o_rsp_valid !== 1'b1) begin
            checks++; errors++;
            $display("FAIL txn_timeout addr=%h: no response within %0d cycles", a, lat);
        end
        rd = o_rsp_rdata;
        e  = o_rsp_err;
        if (i_rsp_ready) begin
            @(posedge i_clk); #1;
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        checks++;
        if (o_req_ready !== 1'b1 || o_rsp_valid !== 1'b0 || o_rsp_rdata !== 32'h0 || o_rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got ready=%b valid=%b rdata=%h err=%b, want 1 0 00000000 0",
                     o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err);
        end
        i_rst = 1'b0;
        @(posedge i_clk); #1;
    endtask

    task automatic test_write_read();
        logic [31:0] rd; logic e; int lat;
        do_txn(32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, rd, e, lat);
        checks++;
        if (lat < LAT_MIN || lat > LAT_MAX) begin
            errors++; $display("FAIL write_latency: got %0d, want %0d..%0d", lat, LAT_MIN, LAT_MAX);
        end
        checks++;
        if (rd !== 32'h0 || e !== 1'b0) begin
            errors++; $display("FAIL write_rsp: got rdata=%h err=%b, want 00000000 0", rd, e);
        end
        checks++;
        if (o_rsp_valid !== 1'b0 || o_req_ready !== 1'b1 || o_rsp_rdata !== 32'h0) begin
            errors++; $display("FAIL post_handshake: got valid=%b ready=%b rdata=%h, want 0 1 00000000",
                               o_rsp_valid, o_req_ready, o_rsp_rdata);
        end
        do_txn(32'h8000_0010, 1'b0, 32'h0, 4'h0, rd, e, lat);
        checks++;
        if (rd !== 32'hDEAD_BEEF || e !== 1'b0) begin
            errors++; $display("FAIL readback: got rdata=%h err=%b, want deadbeef 0", rd, e);
        end
        checks++;
        if (lat < LAT_MIN || lat > LAT_MAX) begin
            errors++; $display("FAIL read_latency: got %0d, want %0d..%0d", lat, LAT_MIN, LAT_MAX);
        end
        do_txn(32'h8000_0013, 1'b0, 32'h0, 4'h0, rd, e, lat);
        checks++;
        if (rd !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL low_addr_bits: got %h, want deadbeef", rd);
        end
    endtask

    task automatic test_wmask();
        logic [31:0] rd; logic e; int lat;
        do_txn(32'h8000_0020, 1'b1, 32'h1122_3344, 4'hF, rd, e, lat);
        do_txn(32'h8000_0020, 1'b1, 32'hAABB_CCDD, 4'b0101, rd, e, lat);
        do_txn(32'h8000_0020, 1'b0, 32'h0, 4'h0, rd, e, lat);
        checks++;
        if (rd !== 32'h11BB_33DD) begin
            errors++; $display("FAIL partial_write: got %h, want 11bb33dd", rd);
        end
        do_txn(32'h8000_0020, 1'b1, 32'hFFFF_FFFF, 4'b0000, rd, e, lat);
        checks++;
        if (rd !== 32'h0 || e !== 1'b0) begin
            errors++; $display("FAIL zero_mask_rsp: got rdata=%h err=%b, want 00000000 0", rd, e);
        end
        do_txn(32'h8000_0020, 1'b0, 32'h0, 4'h0, rd, e, lat);
        checks++;
        if (rd !== 32'h11BB_33DD) begin
            errors++; $display("FAIL zero_mask_data: got %h, want 11bb33dd", rd);
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd; logic e; int lat;
        do_txn(32'h8000_0000, 1'b1, 32'h0BAD_F00D, 4'hF, rd, e, lat);
        do_txn(32'h8000_3FFC, 1'b1, 32'hCAFE_F00D, 4'hF, rd, e, lat);
        do_txn(32'h7FFF_FFFC, 1'b0, 32'h0, 4'h0, rd, e, lat);
        checks++;
        if (rd !== 32'h0 || e !== 1'b1) begin
            errors++; $display("FAIL oor_below: got rdata=%h err=%b, want 00000000 1", rd, e);
        end
        checks++;
        if (lat < LAT_MIN || lat > LAT_MAX) begin
            errors++; $display("FAIL oor_latency: got %0d, want %0d..%0d", lat, LAT_MIN, LAT_MAX);
        end
        do_txn(32'h8000_4000, 1'b0, 32'h0, 4'h0, rd, e, lat);
        checks++;
        if (rd !== 32'h0 || e !== 1'b1) begin
            errors++; $display("FAIL oor_above_read: got rdata=%h err=%b, want 00000000 1", rd, e);
        end
        do_txn(32'h8000_4000, 1'b1, 32'h1234_5678, 4'hF, rd, e, lat);
        checks++;
        if (e !== 1'b1) begin
            errors++; $display("FAIL oor_above_write: got err=%b, want 1", e);
        end
        do_txn(32'h8000_0000, 1'b0, 32'h0, 4'h0, rd, e, lat);
        checks++;
        if (rd !== 32'h0BAD_F00D || e !== 1'b0) begin
            errors++; $display("FAIL oor_no_alias: got rdata=%h err=%b, want 0badf00d 0", rd, e);
        end
        do_txn(32'h8000_3FFC, 1'b0, 32'h0, 4'h0, rd, e, lat);
        checks++;
        if (rd !== 32'hCAFE_F00D || e !== 1'b0) begin
            errors++; $display("FAIL last_word: got rdata=%h err=%b, want cafef00d 0", rd, e);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd; logic e; int lat;
        i_rsp_ready = 1'b0;
        do_txn(32'h8000_0010, 1'b0, 32'h0, 4'h0, rd, e, lat);
        for (int i = 0; i < 5; i++) begin
            i_req_valid = 1'b1; i_req_addr = 32'h8000_0010; i_req_wen = 1'b1;
            i_req_wdata = 32'h0; i_req_wmask = 4'hF;
            @(posedge i_clk); #1;
            checks++;
            if (o_rsp_valid !== 1'b1 || o_rsp_rdata !== 32'hDEAD_BEEF || o_req_ready !== 1'b0 || o_rsp_err !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle%0d: got valid=%b rdata=%h ready=%b err=%b, want 1 deadbeef 0 0",
                         i, o_rsp_valid, o_rsp_rdata, o_req_ready, o_rsp_err);
            end
        end
        i_req_valid = 1'b0;
        i_rsp_ready = 1'b1;
        @(posedge i_clk); #1;
        checks++;
        if (o_rsp_valid !== 1'b0 || o_req_ready !== 1'b1 || o_rsp_rdata !== 32'h0) begin
            errors++; $display("FAIL release: got valid=%b ready=%b rdata=%h, want 0 1 00000000",
                               o_rsp_valid, o_req_ready, o_rsp_rdata);
        end
        do_txn(32'h8000_0010, 1'b0, 32'h0, 4'h0, rd, e, lat);
        checks++;
        if (rd !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL ignored_req: got %h, want deadbeef", rd);
        end
    endtask

    task automatic test_reset_inflight();
        logic [31:0] rd; logic e; int lat;
        do_txn(32'h8000_0030, 1'b1, 32'h5555_5555, 4'hF, rd, e, lat);
        i_req_valid = 1'b1; i_req_addr = 32'h8000_0030; i_req_wen = 1'b1;
        i_req_wdata = 32'h0; i_req_wmask = 4'hF;
        @(posedge i_clk); #1;
        i_req_valid = 1'b0;
        checks++;
        if (o_req_ready !== 1'b0) begin
            errors++; $display("FAIL inflight_accept: got ready=%b, want 0", o_req_ready);
        end
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        checks++;
        if (o_req_ready !== 1'b1 || o_rsp_valid !== 1'b0 || o_rsp_rdata !== 32'h0 || o_rsp_err !== 1'b0) begin
            errors++; $display("FAIL inflight_reset: got ready=%b valid=%b rdata=%h err=%b, want 1 0 00000000 0",
                               o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err);
        end
        i_rst = 1'b0;
        @(posedge i_clk); #1;
        do_txn(32'h8000_0030, 1'b0, 32'h0, 4'h0, rd, e, lat);
        checks++;
        if (rd !== 32'h5555_5555) begin
            errors++; $display("FAIL aborted_write: got %h, want 55555555", rd);
        end
        do_txn(32'h8000_0010, 1'b0, 32'h0, 4'h0, rd, e, lat);
        checks++;
        if (rd !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL storage_kept: got %h, want deadbeef", rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic e; int lat;
        do_txn(32'h8000_0010, 1'b0, 32'h0, 4'h0, rd, e, lat);
        checks++;
        if (o_req_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_idle: got ready=%b, want 1", o_req_ready);
        end
        do_txn(32'h8000_0020, 1'b0, 32'h0, 4'h0, rd, e, lat);
        checks++;
        if (rd !== 32'h11BB_33DD) begin
            errors++; $display("FAIL b2b_second: got %h, want 11bb33dd", rd);
        end
    endtask

`ifdef YSYX_24090003_MEM_RAND_DELAY_EN
    task automatic test_rand_delay();
        logic [31:0] rd; logic e; int lat;
        logic [31:0] exp_d;
        for (int i = 0; i < 100; i++) begin
            exp_d = (i % 2 == 0) ? 32'hDEAD_BEEF : 32'h11BB_33DD;
            do_txn((i % 2 == 0) ? 32'h8000_0010 : 32'h8000_0020, 1'b0, 32'h0, 4'h0, rd, e, lat);
            checks++;
            if (lat < 1 || lat > 4 || rd !== exp_d) begin
                errors++; $display("FAIL rand_read%0d: got lat=%0d rdata=%h, want 1..4 %h", i, lat, rd, exp_d);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_wmask();
        test_out_of_range();
        test_backpressure();
        test_reset_inflight();
        test_back_to_back();
`ifdef YSYX_24090003_MEM_RAND_DELAY_EN
        test_rand_delay();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
